rr_decode_arbiter: RTL

//  Round-robin arbiter that shares one 3-to-8 decoded resource among 8 requesters.

---
 rtl/rr_decode_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/rr_decode_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_decode_arbiter
// Description : Round-robin arbiter that shares one 3-to-8 decoded resource
//               among 8 requesters. The owner index is driven on sel
//               (sel[0] feeds decoder in1), with a matching one-hot grant.
//               Each grant lasts at most HOLD_MAX cycles. One dead cycle
//               always follows the end of a grant.
// Ports       : sys_clk     - system clock, rising edge
//               sys_rst     - synchronous reset, active-high
//               req[7:0]    - level requests, held until served
//               sel[2:0]    - current/last owner index {in3,in2,in1}
//               grant[7:0]  - one-hot grant, zero when grant_valid=0
//               grant_valid - a grant is active this cycle
//               timeout     - 1-cycle pulse when a grant ends by HOLD_MAX
// Revision    : 1.0 - initial release
// ============================================================================
module rr_decode_arbiter #(
    parameter int HOLD_MAX = 16,
    parameter int CNT_W    = 8
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [7:0] req,
    output logic [2:0] sel,
    output logic [7:0] grant,
    output logic       grant_valid,
    output logic       timeout
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] C_HOLD_LAST = CNT_W'(HOLD_MAX - 1);

    state_t           r_state, w_state;
    logic [2:0]       r_sel, w_sel;
    logic             r_gv, w_gv;
    logic             r_timeout, w_timeout;
    logic [2:0]       r_ptr, w_ptr;
    logic [CNT_W-1:0] r_cnt, w_cnt;

    logic [2:0]       w_pick;
    logic             w_any;

    // First set request searching ptr, ptr+1, ... (mod 8). Scanning from the
    // farthest offset down lets the nearest hit overwrite the others.
    always_comb begin
        w_pick = r_ptr;
        w_any  = |req;
        for (int i = 7; i >= 0; i--) begin
            if (req[r_ptr + 3'(i)]) begin
                w_pick = r_ptr + 3'(i);
            end
        end
    end

    always_comb begin
        w_state   = r_state;
        w_sel     = r_sel;
        w_gv      = r_gv;
        w_timeout = 1'b0;
        w_ptr     = r_ptr;
        w_cnt     = r_cnt;
        case (r_state)
            ST_IDLE, ST_GAP: begin
                w_gv = 1'b0;
                if (w_any) begin
                    w_sel   = w_pick;
                    w_gv    = 1'b1;
                    w_cnt   = '0;
                    w_state = ST_GRANT;
                end else begin
                    w_state = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (!req[r_sel]) begin
                    // Voluntary release wins even on the final allowed cycle.
                    w_gv    = 1'b0;
                    w_ptr   = r_sel + 3'd1;
                    w_state = ST_GAP;
                end else if (r_cnt == C_HOLD_LAST) begin
                    w_gv      = 1'b0;
                    w_ptr     = r_sel + 3'd1;
                    w_timeout = 1'b1;
                    w_state   = ST_GAP;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_gv    = 1'b0;
                w_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state   <= ST_IDLE;
            r_sel     <= 3'd0;
            r_gv      <= 1'b0;
            r_timeout <= 1'b0;
            r_ptr     <= 3'd0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state;
            r_sel     <= w_sel;
            r_gv      <= w_gv;
            r_timeout <= w_timeout;
            r_ptr     <= w_ptr;
            r_cnt     <= w_cnt;
        end
    end

    assign sel         = r_sel;
    assign grant_valid = r_gv;
    assign timeout     = r_timeout;
    assign grant       = r_gv ? (8'b1 << r_sel) : 8'h00;

endmodule
`default_nettype wire
